// File: rtl/min_injector_pkg.sv
// Shared types for the MIN injector: FSM state encoding and counter width.
package min_injector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int COUNT_W = 32;

endpackage

// File: rtl/min_port_fifo.sv
// Per-port synchronous FIFO holding {dest, data}; head word visible combinationally.
module min_port_fifo #(
  parameter int DATA_W = 68,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic              last
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       count;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(wr_en) - (PW+1)'(rd_en);
    end
  end

  // Storage carries no reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign last    = (count == (PW+1)'(1));

endmodule

// File: rtl/min_injector.sv
// Transmit front end for the XOR-permutation MIN: launches each buffered word when
// port ^ sched equals its destination. Optional MIN_INJECTOR_COUNT_EN adds launch_count.
module min_injector
  import min_injector_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int PORTS      = 16,
  parameter int ADDR_WIDTH = $clog2(PORTS),
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [0:PORTS-1]            in_valid,
  output logic [0:PORTS-1]            in_ready,
  input  logic [PORTS*WIDTH-1:0]      in_data,
  input  logic [PORTS*ADDR_WIDTH-1:0] in_dest,
  input  logic                        flush,
  output logic                        flush_done,
  output logic [0:PORTS-1]            push,
  output logic [PORTS*WIDTH-1:0]      d_out,
  output logic [ADDR_WIDTH-1:0]       control
`ifdef MIN_INJECTOR_COUNT_EN
  ,
  output logic [COUNT_W-1:0]          launch_count
`endif
);

  state_t                state;
  state_t                state_nxt;
  logic                  done_nxt;
  logic [ADDR_WIDTH-1:0] sched;
  logic [0:PORTS-1]      wr;
  logic [0:PORTS-1]      launch;
  logic [0:PORTS-1]      full;
  logic [0:PORTS-1]      empty;
  logic [0:PORTS-1]      last;
  logic                  active;
  logic                  empty_after;

  assign active      = (state == ST_RUN) || (state == ST_DRAIN);
  assign empty_after = &(empty | (last & launch));

  for (genvar i = 0; i < PORTS; i++) begin : g_port
    logic [WIDTH+ADDR_WIDTH-1:0] head;
    logic [WIDTH-1:0]            dout_q;

    assign in_ready[i] = ~full[i] && (state != ST_DRAIN);
    assign wr[i]       = in_valid[i] & in_ready[i];
    assign launch[i]   = active && !empty[i] &&
                         (head[WIDTH+ADDR_WIDTH-1 -: ADDR_WIDTH] == (ADDR_WIDTH'(i) ^ sched));

    min_port_fifo #(
      .DATA_W (WIDTH + ADDR_WIDTH),
      .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr[i]),
      .wr_data ({in_dest[ADDR_WIDTH*(PORTS-i)-1 -: ADDR_WIDTH],
                 in_data[WIDTH*(PORTS-i)-1 -: WIDTH]}),
      .rd_en   (launch[i]),
      .rd_data (head),
      .full    (full[i]),
      .empty   (empty[i]),
      .last    (last[i])
    );

    // Launch stage: d_out holds the last launched word of this port.
    always_ff @(posedge clk) begin
      if (rst)            dout_q <= '0;
      else if (launch[i]) dout_q <= head[WIDTH-1:0];
    end

    assign d_out[WIDTH*(PORTS-i)-1 -: WIDTH] = dout_q;
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (flush)                   state_nxt = ST_DRAIN;
        else if (!(&empty) || |wr)   state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (flush)                   state_nxt = ST_DRAIN;
        else if (empty_after && !(|wr)) state_nxt = ST_IDLE;
      end
      ST_DRAIN: begin
        if (&empty) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      sched      <= '0;
      control    <= '0;
      push       <= '0;
      flush_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      flush_done <= done_nxt;
      push       <= launch;
      if (active) begin
        control <= sched;
        sched   <= sched + 1'b1;
      end
    end
  end

`ifdef MIN_INJECTOR_COUNT_EN
  function automatic logic [COUNT_W-1:0] ones(input logic [0:PORTS-1] v);
    logic [COUNT_W-1:0] n;
    n = '0;
    for (int k = 0; k < PORTS; k++) n = n + COUNT_W'(v[k]);
    return n;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) launch_count <= '0;
    else     launch_count <= launch_count + ones(launch);
  end
`endif

endmodule

// File: tb/tb_min_injector.sv
// Randomized and directed bench for min_injector against a queue-based reference model.
module tb_min_injector;
  localparam int WIDTH = 64;
  localparam int PORTS = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [0:PORTS-1]       in_valid;
  logic [0:PORTS-1]       in_ready;
  logic [PORTS*WIDTH-1:0] in_data;
  logic [PORTS*AW-1:0]    in_dest;
  logic                   flush;
  logic                   flush_done;
  logic [0:PORTS-1]       push;
  logic [PORTS*WIDTH-1:0] d_out;
  logic [AW-1:0]          control;
`ifdef MIN_INJECTOR_COUNT_EN
  logic [31:0]            launch_count;
`endif

  always #5 clk = ~clk;

  min_injector #(
    .WIDTH(WIDTH), .PORTS(PORTS), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_dest    (in_dest),
    .flush      (flush),
    .flush_done (flush_done),
    .push       (push),
    .d_out      (d_out),
    .control    (control)
`ifdef MIN_INJECTOR_COUNT_EN
    ,
    .launch_count (launch_count)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cycle_no = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle_no);
    end
  endtask

  // Reference model: one queue per port, a mode word and a free-running slot counter.
  typedef struct packed {
    logic [AW-1:0]    dest;
    logic [WIDTH-1:0] data;
  } word_t;

  word_t            q [PORTS][$];
  int               m_mode;   // 0 idle, 1 run, 2 drain
  int               m_sched;
  logic [WIDTH-1:0] m_dout [PORTS];
  logic [0:PORTS-1] m_push;
  logic [AW-1:0]    m_ctrl;
  logic             m_done;
  logic [31:0]      m_count;
  logic [0:PORTS-1] acc;

  function automatic logic [WIDTH-1:0] port_data(input int i);
    return in_data[WIDTH*(PORTS-i)-1 -: WIDTH];
  endfunction

  function automatic logic [AW-1:0] port_dest(input int i);
    return in_dest[AW*(PORTS-i)-1 -: AW];
  endfunction

  function automatic logic [WIDTH-1:0] dout_of(input int i);
    return d_out[WIDTH*(PORTS-i)-1 -: WIDTH];
  endfunction

  task automatic set_port(input int i, input logic v, input logic [WIDTH-1:0] d, input logic [AW-1:0] t);
    in_valid[i] = v;
    in_data[WIDTH*(PORTS-i)-1 -: WIDTH] = d;
    in_dest[AW*(PORTS-i)-1 -: AW] = t;
  endtask

  task automatic clear_inputs();
    in_valid = '0;
    in_data  = '0;
    in_dest  = '0;
  endtask

  // One clock: model consumes the inputs, then DUT outputs are compared after the edge.
  task automatic step();
    logic wr [PORTS];
    logic rdy, any_ne, any_wr, all_e;
    int   nl;
    #1;
    if (rst) begin
      for (int i = 0; i < PORTS; i++) begin
        q[i].delete();
        m_dout[i] = '0;
      end
      m_mode = 0; m_sched = 0; m_push = '0; m_ctrl = '0; m_done = 1'b0; m_count = '0; acc = '0;
    end else begin
      any_ne = 1'b0; any_wr = 1'b0; nl = 0;
      for (int i = 0; i < PORTS; i++) begin
        rdy = (q[i].size() < DEPTH) && (m_mode != 2);
        check("in_ready", in_ready[i], rdy);
        wr[i]  = in_valid[i] && rdy;
        acc[i] = wr[i];
        any_wr |= wr[i];
        any_ne |= (q[i].size() != 0);
      end
      m_done = 1'b0;
      m_push = '0;
      if (m_mode != 0) begin
        for (int i = 0; i < PORTS; i++) begin
          if (q[i].size() > 0 && q[i][0].dest == AW'(i ^ m_sched)) begin
            m_push[i] = 1'b1;
            m_dout[i] = q[i][0].data;
            void'(q[i].pop_front());
            nl++;
          end
        end
        m_ctrl  = AW'(m_sched);
        m_sched = (m_sched + 1) % PORTS;
      end
      for (int i = 0; i < PORTS; i++)
        if (wr[i]) q[i].push_back({port_dest(i), port_data(i)});
      all_e = 1'b1;
      for (int i = 0; i < PORTS; i++) if (q[i].size() != 0) all_e = 1'b0;
      m_count += 32'(nl);
      case (m_mode)
        0: if (flush) m_mode = 2; else if (any_ne || any_wr) m_mode = 1;
        1: if (flush) m_mode = 2; else if (all_e && !any_wr) m_mode = 0;
        default: if (!any_ne) begin m_mode = 0; m_done = 1'b1; end
      endcase
    end
    @(posedge clk);
    #1;
    cycle_no++;
    check("push", push, m_push);
    check("control", control, m_ctrl);
    check("flush_done", flush_done, m_done);
    for (int i = 0; i < PORTS; i++) check("d_out", dout_of(i), m_dout[i]);
`ifdef MIN_INJECTOR_COUNT_EN
    check("launch_count", launch_count, m_count);
`endif
    @(negedge clk);
  endtask

  task automatic run_idle(input int max);
    for (int k = 0; k < max && m_mode != 0; k++) step();
    step();
  endtask

  initial begin
    int   n, pulses, done_k, last_push_k;
    logic found;
    int   p0_t [$];
    logic [WIDTH-1:0] p0_d [$];
    logic stalled;

    clear_inputs();
    flush = 1'b0;
    rst   = 1'b1;
    step();
    step();
    check("rst_push", push, 16'h0);
    check("rst_ctrl", control, 4'h0);
    check("rst_done", flush_done, 1'b0);
    rst = 1'b0;
    #1;
    check("rst_ready", in_ready, 16'hFFFF);

    // Single word, port 3 -> dest 5: launches on slot 6.
    set_port(3, 1'b1, 64'hA5, 4'd5);
    step();
    clear_inputs();
    found = 1'b0; n = 0;
    for (int k = 1; k <= 20 && !found; k++) begin
      step();
      if (push[3]) begin
        found = 1'b1; n = k;
        check("t2_ctrl", control, 4'd6);
        check("t2_data", dout_of(3), 64'hA5);
        check("t2_only", push, 16'h1000);
      end
    end
    check("t2_found", found, 1'b1);
    check("t2_latency", n, 7);
    run_idle(5);

    // All ports at once with dest = i^2: a single broadcast slot.
    for (int i = 0; i < PORTS; i++) set_port(i, 1'b1, {$urandom, $urandom}, AW'(i ^ 2));
    step();
    clear_inputs();
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (push != '0) begin
        found = 1'b1;
        check("t3_push", push, 16'hFFFF);
        check("t3_ctrl", control, 4'd2);
      end
    end
    check("t3_found", found, 1'b1);
    run_idle(5);
    check("t3_ready", in_ready, 16'hFFFF);

    // Five words to one port (depth 4): fifth stalls, launches 16 cycles apart.
    stalled = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_port(0, 1'b1, 64'hB000 + 64'(k), 4'd1);
      for (int g = 0; g < 60; g++) begin
        step();
        if (push[0]) begin p0_t.push_back(cycle_no); p0_d.push_back(dout_of(0)); end
        if (acc[0]) break;
        stalled = 1'b1;
      end
    end
    clear_inputs();
    for (int g = 0; g < 100 && p0_t.size() < 5; g++) begin
      step();
      if (push[0]) begin p0_t.push_back(cycle_no); p0_d.push_back(dout_of(0)); end
    end
    check("t4_stall", stalled, 1'b1);
    check("t4_count", p0_t.size(), 5);
    for (int k = 0; k < p0_t.size(); k++) begin
      check("t4_order", p0_d[k], 64'hB000 + 64'(k));
      if (k > 0) check("t4_spacing", p0_t[k] - p0_t[k-1], 16);
    end
    run_idle(20);

    // Flush with three buffered words; flush held for two cycles.
    for (int i = 1; i <= 3; i++)
      set_port(i, 1'b1, {$urandom, $urandom}, AW'(i ^ ((m_sched + 5 + i) % PORTS)));
    step();
    clear_inputs();
    flush = 1'b1;
    step();
    check("t5_ready", in_ready, 16'h0);
    pulses = 0; done_k = -1; last_push_k = -1;
    for (int k = 0; k < 40; k++) begin
      if (k == 1) flush = 1'b0;
      step();
      if (push != '0) last_push_k = k;
      if (flush_done) begin pulses++; done_k = k; end
    end
    check("t5_pulses", pulses, 1);
    check("t5_after_last", done_k > last_push_k, 1'b1);
    check("t5_ready_after", in_ready, 16'hFFFF);

    // Flush with nothing buffered: done after one DRAIN cycle.
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    check("t5e_done", flush_done, 1'b1);
    step();

    // Randomized traffic with occasional flushes.
    for (int k = 0; k < 500; k++) begin
      for (int i = 0; i < PORTS; i++)
        set_port(i, ($urandom_range(0, 9) < 3), {$urandom, $urandom}, AW'($urandom_range(0, PORTS-1)));
      flush = ($urandom_range(0, 49) == 0);
      step();
    end
    clear_inputs();
    flush = 1'b1;
    step();
    flush = 1'b0;
    run_idle(60);

    // Reset in the middle of heavy traffic.
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < PORTS; i++)
        set_port(i, 1'b1, {$urandom, $urandom}, AW'($urandom_range(0, PORTS-1)));
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_inputs();
`ifdef MIN_INJECTOR_COUNT_EN
    check("t6_count", launch_count, 32'd0);
`endif
    for (int k = 0; k < 20; k++) begin
      step();
      check("t6_push", push, 16'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
